nios2_oci_mem_arbiter: RTL and testbench

- Sysclk-domain controller that shares the single port of the on-chip debug memory (OCI RAM plus debug registers) between two requesters: the JTAG debug path and the CPU-side Avalon slave.
- The JTAG path issues pulse commands (take_action style) and owns an auto-incrementing address pointer.
- The Avalon path uses waitrequest flow control.
- The block sequences each access through a small FSM, applies round-robin arbitration and returns read data to the granted requester.

---
 rtl/nios2_oci_mem_arbiter_if.sv | 52 +++++
 rtl/nios2_oci_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_nios2_oci_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_oci_mem_arbiter_if.sv
// Bundle of the JTAG command path, the Avalon slave and the debug-memory port
// served by nios2_oci_mem_arbiter.
interface nios2_oci_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              jtag_addr_load;
   logic [ADDR_W-1:0] jtag_addr;
   logic              jtag_req;
   logic              jtag_write;
   logic              jtag_inc;
   logic [DATA_W-1:0] jtag_wdata;
   logic              jtag_clr_err;
   logic              jtag_ack;
   logic [DATA_W-1:0] jtag_rdata;
   logic              jtag_busy;
   logic              jtag_overrun;
   logic [ADDR_W-1:0] jtag_ptr;

   logic              avl_read;
   logic              avl_write;
   logic [ADDR_W-1:0] avl_address;
   logic [DATA_W-1:0] avl_writedata;
   logic [BE_W-1:0]   avl_byteenable;
   logic              avl_waitrequest;
   logic [DATA_W-1:0] avl_readdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  jtag_addr_load, jtag_addr, jtag_req, jtag_write, jtag_inc, jtag_wdata,
             jtag_clr_err, avl_read, avl_write, avl_address, avl_writedata,
             avl_byteenable, mem_rdata,
      output jtag_ack, jtag_rdata, jtag_busy, jtag_overrun, jtag_ptr, avl_waitrequest,
             avl_readdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output jtag_addr_load, jtag_addr, jtag_req, jtag_write, jtag_inc, jtag_wdata,
             jtag_clr_err, avl_read, avl_write, avl_address, avl_writedata,
             avl_byteenable, mem_rdata,
      input  jtag_ack, jtag_rdata, jtag_busy, jtag_overrun, jtag_ptr, avl_waitrequest,
             avl_readdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/nios2_oci_mem_arbiter.sv
// Round-robin sharing of the OCI debug memory port between the JTAG command path
// and the CPU-side Avalon slave; one access at a time through IDLE/ACCESS/RDWAIT/DONE.
module nios2_oci_mem_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned RD_LATENCY = 1
) (
   input logic                    clk,
   input logic                    reset,
   nios2_oci_mem_arbiter_if.slave bus
);
   localparam int unsigned BE_W = DATA_W / 8;

   typedef enum logic [1:0] {StIdle, StAccess, StRdWait, StDone} state_e;

   state_e            state_q, state_d;
   logic              grant_jtag_q, grant_jtag_d;
   logic              last_jtag_q, last_jtag_d;
   logic              is_write_q, is_write_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              pend_write_q, pend_write_d;
   logic              pend_inc_q, pend_inc_d;
   logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] jtag_rdata_q, jtag_rdata_d;
   logic [DATA_W-1:0] avl_rdata_q, avl_rdata_d;
   logic              ack_q, ack_d;
   logic              waitreq_q, waitreq_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic              busy, jtag_new, jtag_cand, avl_cand, rd_done;

   always_comb begin
      busy      = pend_q | ((state_q != StIdle) & grant_jtag_q);
      jtag_new  = bus.jtag_req & ~busy;
      jtag_cand = pend_q | jtag_new;
      avl_cand  = bus.avl_read | bus.avl_write;

      state_d      = state_q;
      grant_jtag_d = grant_jtag_q;
      last_jtag_d  = last_jtag_q;
      is_write_d   = is_write_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      pend_write_d = pend_write_q;
      pend_inc_d   = pend_inc_q;
      pend_wdata_d = pend_wdata_q;
      ptr_d        = ptr_q;
      overrun_d    = overrun_q;
      jtag_rdata_d = jtag_rdata_q;
      avl_rdata_d  = avl_rdata_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;

      if (jtag_new) begin
         pend_d       = 1'b1;
         pend_write_d = bus.jtag_write;
         pend_inc_d   = bus.jtag_inc;
         pend_wdata_d = bus.jtag_wdata;
      end
      if (bus.jtag_clr_err) overrun_d = 1'b0;
      if (bus.jtag_req & busy) overrun_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (jtag_cand | avl_cand) begin
               // On a tie the requester that did not win last time goes first.
               grant_jtag_d = jtag_cand & (~avl_cand | ~last_jtag_q);
               last_jtag_d  = grant_jtag_d;
               state_d      = StAccess;
               mem_en_d     = 1'b1;
               if (grant_jtag_d) begin
                  // A request arriving this cycle is not yet in the pending latch.
                  is_write_d  = pend_q ? pend_write_q : bus.jtag_write;
                  mem_wdata_d = pend_q ? pend_wdata_q : bus.jtag_wdata;
                  mem_addr_d  = ptr_q;
                  mem_be_d    = '1;
               end else begin
                  is_write_d  = bus.avl_write;
                  mem_wdata_d = bus.avl_writedata;
                  mem_addr_d  = bus.avl_address;
                  mem_be_d    = bus.avl_byteenable;
               end
               mem_we_d = is_write_d;
            end
         end
         StAccess: begin
            if (is_write_q || RD_LATENCY == 1) begin
               state_d = StDone;
            end else begin
               state_d = StRdWait;
               cnt_d   = 2'(RD_LATENCY - 1);
            end
         end
         StRdWait: begin
            if (cnt_q == 2'd1) state_d = StDone;
            else cnt_d = cnt_q - 2'd1;
         end
         StDone: begin
            state_d = StIdle;
            if (grant_jtag_q) begin
               pend_d = 1'b0;
               if (pend_inc_q) ptr_d = ptr_q + 1'b1;
               if (!is_write_q) jtag_rdata_d = bus.mem_rdata;
            end else if (!is_write_q) begin
               avl_rdata_d = bus.mem_rdata;
            end
         end
         default: state_d = StIdle;
      endcase

      if (bus.jtag_addr_load) ptr_d = bus.jtag_addr;

      ack_d     = (state_d == StDone) & grant_jtag_d;
      waitreq_d = ~((state_d == StDone) & ~grant_jtag_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_jtag_q <= 1'b0;
         last_jtag_q  <= 1'b0;
         is_write_q   <= 1'b0;
         cnt_q        <= 2'd0;
         pend_q       <= 1'b0;
         pend_write_q <= 1'b0;
         pend_inc_q   <= 1'b0;
         pend_wdata_q <= '0;
         ptr_q        <= '0;
         overrun_q    <= 1'b0;
         jtag_rdata_q <= '0;
         avl_rdata_q  <= '0;
         ack_q        <= 1'b0;
         waitreq_q    <= 1'b1;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_jtag_q <= grant_jtag_d;
         last_jtag_q  <= last_jtag_d;
         is_write_q   <= is_write_d;
         cnt_q        <= cnt_d;
         pend_q       <= pend_d;
         pend_write_q <= pend_write_d;
         pend_inc_q   <= pend_inc_d;
         pend_wdata_q <= pend_wdata_d;
         ptr_q        <= ptr_d;
         overrun_q    <= overrun_d;
         jtag_rdata_q <= jtag_rdata_d;
         avl_rdata_q  <= avl_rdata_d;
         ack_q        <= ack_d;
         waitreq_q    <= waitreq_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
      end
   end

   // Read data is only on mem_rdata during DONE, so pass it through then and hold after.
   assign rd_done          = (state_q == StDone) & ~is_write_q;
   assign bus.jtag_rdata   = (rd_done & grant_jtag_q) ? bus.mem_rdata : jtag_rdata_q;
   assign bus.avl_readdata = (rd_done & ~grant_jtag_q) ? bus.mem_rdata : avl_rdata_q;

   assign bus.jtag_ack        = ack_q;
   assign bus.jtag_busy       = busy;
   assign bus.jtag_overrun    = overrun_q;
   assign bus.jtag_ptr        = ptr_q;
   assign bus.avl_waitrequest = waitreq_q;
   assign bus.mem_en          = mem_en_q;
   assign bus.mem_we          = mem_we_q;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_wdata       = mem_wdata_q;
   assign bus.mem_be          = mem_be_q;
endmodule

// File: tb/tb_nios2_oci_mem_arbiter.sv
// Scoreboard bench for nios2_oci_mem_arbiter: stimulus queues expected memory
// accesses and completions, a negedge monitor pops and compares them.
module tb_nios2_oci_mem_arbiter;
   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned RD_LATENCY = 3;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   nios2_oci_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   nios2_oci_mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: byte-enabled writes, reads delivered RD_LATENCY cycles after mem_en.
   logic [31:0] mem [256];
   logic [31:0] rd_pipe [RD_LATENCY];
   always @(posedge clk) begin
      if (reset) begin
         mem[8'h05] <= 32'h1234_5678;
         mem[8'h20] <= 32'hAAAA_AAAA;
         mem[8'h21] <= 32'h5555_5555;
         mem[8'hFF] <= 32'hCAFE_F00D;
      end else if (bus.mem_en && bus.mem_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'h0BAD_0BAD;
      for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bus.mem_rdata = rd_pipe[RD_LATENCY-1];

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          cyc;
   } mem_exp_t;

   typedef struct {
      logic        is_jtag;
      logic        rd;
      logic [31:0] rdata;
      int          cyc;
   } done_exp_t;

   mem_exp_t  mq[$];
   done_exp_t dq[$];
   mem_exp_t  m_item;
   done_exp_t d_item;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_mem(input logic we, input logic [7:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int c);
      mem_exp_t e;
      e.we = we; e.addr = a; e.wdata = wd; e.be = be; e.cyc = c;
      mq.push_back(e);
   endtask

   task automatic push_done(input logic j, input logic rd, input logic [31:0] rdat,
                            input int c);
      done_exp_t e;
      e.is_jtag = j; e.rd = rd; e.rdata = rdat; e.cyc = c;
      dq.push_back(e);
   endtask

   // Monitor: cyc < 0 in an expectation means cycle is not checked.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_en) begin
            if (mq.size() == 0) begin
               chk("unexpected_mem_en", 32'd1, 32'd0);
            end else begin
               m_item = mq.pop_front();
               chk("mem_we", 32'(bus.mem_we), 32'(m_item.we));
               chk("mem_addr", 32'(bus.mem_addr), 32'(m_item.addr));
               chk("mem_be", 32'(bus.mem_be), 32'(m_item.be));
               if (m_item.we) chk("mem_wdata", bus.mem_wdata, m_item.wdata);
               if (m_item.cyc >= 0) chk("mem_en_cycle", cyc, m_item.cyc);
            end
         end
         if (bus.jtag_ack || !bus.avl_waitrequest) begin
            if (dq.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               d_item = dq.pop_front();
               chk("completion_src", 32'(bus.jtag_ack), 32'(d_item.is_jtag));
               chk("single_completion", 32'(bus.jtag_ack & ~bus.avl_waitrequest), 32'd0);
               if (d_item.rd)
                  chk(d_item.is_jtag ? "jtag_rdata" : "avl_readdata",
                      d_item.is_jtag ? bus.jtag_rdata : bus.avl_readdata, d_item.rdata);
               if (d_item.cyc >= 0) chk("completion_cycle", cyc, d_item.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic jtag_cmd(input logic wr, input logic inc, input logic [31:0] wd);
      bus.jtag_req = 1'b1; bus.jtag_write = wr; bus.jtag_inc = inc; bus.jtag_wdata = wd;
      tick();
      bus.jtag_req = 1'b0;
   endtask

   task automatic load_ptr(input logic [7:0] a);
      bus.jtag_addr_load = 1'b1; bus.jtag_addr = a;
      tick();
      bus.jtag_addr_load = 1'b0;
   endtask

   // Returns one cycle after the ack cycle.
   task automatic wait_ack();
      int n = 0;
      while (!bus.jtag_ack && n < 40) begin tick(); n++; end
      chk("jtag_ack_timeout", 32'(bus.jtag_ack), 32'd1);
      tick();
   endtask

   task automatic wait_avl_done();
      int n = 0;
      do begin tick(); n++; end while (bus.avl_waitrequest && n < 40);
      chk("avl_timeout", 32'(bus.avl_waitrequest), 32'd0);
      tick();
   endtask

   task automatic avl_xfer(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
      bus.avl_read = rd; bus.avl_write = wr; bus.avl_address = a;
      bus.avl_writedata = wd; bus.avl_byteenable = be;
      wait_avl_done();
      bus.avl_read = 1'b0; bus.avl_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      reset = 1'b1;
      bus.jtag_addr_load = 0; bus.jtag_addr = '0; bus.jtag_req = 0; bus.jtag_write = 0;
      bus.jtag_inc = 0; bus.jtag_wdata = '0; bus.jtag_clr_err = 0;
      bus.avl_read = 0; bus.avl_write = 0; bus.avl_address = '0;
      bus.avl_writedata = '0; bus.avl_byteenable = '0;
      tick(); tick(); tick();
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_waitrequest", 32'(bus.avl_waitrequest), 32'd1);
      chk("rst_ack", 32'(bus.jtag_ack), 32'd0);
      chk("rst_busy", 32'(bus.jtag_busy), 32'd0);
      chk("rst_overrun", 32'(bus.jtag_overrun), 32'd0);
      chk("rst_ptr", 32'(bus.jtag_ptr), 32'd0);
      chk("rst_jtag_rdata", bus.jtag_rdata, 32'd0);
      chk("rst_avl_readdata", bus.avl_readdata, 32'd0);
      reset = 1'b0;
      tick();

      // JTAG write with increment, then read it back.
      load_ptr(8'h10);
      t = cyc;
      push_mem(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, t + 1);
      push_done(1'b1, 1'b0, 32'h0, t + 2);
      jtag_cmd(1'b1, 1'b1, 32'hDEAD_BEEF);
      wait_ack();
      chk("ptr_after_inc", 32'(bus.jtag_ptr), 32'h11);
      chk("busy_after_done", 32'(bus.jtag_busy), 32'd0);
      load_ptr(8'h10);
      t = cyc;
      push_mem(1'b0, 8'h10, 32'h0, 4'hF, t + 1);
      push_done(1'b1, 1'b1, 32'hDEAD_BEEF, t + 4);
      jtag_cmd(1'b0, 1'b1, 32'h0);
      wait_ack();
      chk("ptr_after_read", 32'(bus.jtag_ptr), 32'h11);

      // Avalon read, latency 3.
      t = cyc;
      push_mem(1'b0, 8'h05, 32'h0, 4'hF, t + 1);
      push_done(1'b0, 1'b1, 32'h1234_5678, t + 4);
      avl_xfer(1'b1, 1'b0, 8'h05, 32'h0, 4'hF);

      // Contention: last winner was Avalon, so JTAG, AVL, JTAG, AVL.
      push_mem(1'b1, 8'h11, 32'h1111_1111, 4'hF, -1);
      push_mem(1'b1, 8'h20, 32'h0000_BEEF, 4'h3, -1);
      push_mem(1'b1, 8'h11, 32'h2222_2222, 4'hF, -1);
      push_mem(1'b1, 8'h21, 32'h1234_0000, 4'hC, -1);
      push_done(1'b1, 1'b0, 32'h0, -1);
      push_done(1'b0, 1'b0, 32'h0, -1);
      push_done(1'b1, 1'b0, 32'h0, -1);
      push_done(1'b0, 1'b0, 32'h0, -1);
      fork
         begin
            jtag_cmd(1'b1, 1'b0, 32'h1111_1111);
            wait_ack();
            jtag_cmd(1'b1, 1'b0, 32'h2222_2222);
            wait_ack();
         end
         begin
            bus.avl_write = 1'b1; bus.avl_address = 8'h20;
            bus.avl_writedata = 32'h0000_BEEF; bus.avl_byteenable = 4'h3;
            wait_avl_done();
            bus.avl_address = 8'h21;
            bus.avl_writedata = 32'h1234_0000; bus.avl_byteenable = 4'hC;
            wait_avl_done();
            bus.avl_write = 1'b0;
         end
      join
      push_mem(1'b0, 8'h20, 32'h0, 4'hF, -1);
      push_done(1'b0, 1'b1, 32'hAAAA_BEEF, -1);
      avl_xfer(1'b1, 1'b0, 8'h20, 32'h0, 4'hF);
      // Read and write both high counts as a write.
      push_mem(1'b1, 8'h21, 32'h0000_0099, 4'h1, -1);
      push_done(1'b0, 1'b0, 32'h0, -1);
      avl_xfer(1'b1, 1'b1, 8'h21, 32'h0000_0099, 4'h1);
      push_mem(1'b0, 8'h21, 32'h0, 4'hF, -1);
      push_done(1'b0, 1'b1, 32'h1234_5599, -1);
      avl_xfer(1'b1, 1'b0, 8'h21, 32'h0, 4'hF);

      // Overrun: request while busy is dropped, clear works, same-cycle set wins.
      push_mem(1'b0, 8'h11, 32'h0, 4'hF, -1);
      push_done(1'b1, 1'b1, 32'h2222_2222, -1);
      jtag_cmd(1'b0, 1'b0, 32'h0);
      chk("busy_in_service", 32'(bus.jtag_busy), 32'd1);
      jtag_cmd(1'b0, 1'b0, 32'h0);
      chk("overrun_set", 32'(bus.jtag_overrun), 32'd1);
      wait_ack();
      bus.jtag_clr_err = 1'b1;
      tick();
      bus.jtag_clr_err = 1'b0;
      chk("overrun_cleared", 32'(bus.jtag_overrun), 32'd0);
      push_mem(1'b0, 8'h11, 32'h0, 4'hF, -1);
      push_done(1'b1, 1'b1, 32'h2222_2222, -1);
      jtag_cmd(1'b0, 1'b0, 32'h0);
      bus.jtag_clr_err = 1'b1;
      jtag_cmd(1'b0, 1'b0, 32'h0);
      bus.jtag_clr_err = 1'b0;
      chk("overrun_set_wins", 32'(bus.jtag_overrun), 32'd1);
      wait_ack();
      bus.jtag_clr_err = 1'b1;
      tick();
      bus.jtag_clr_err = 1'b0;
      chk("overrun_cleared2", 32'(bus.jtag_overrun), 32'd0);

      // Pointer wrap, then a load coinciding with DONE.
      load_ptr(8'hFF);
      push_mem(1'b0, 8'hFF, 32'h0, 4'hF, -1);
      push_done(1'b1, 1'b1, 32'hCAFE_F00D, -1);
      jtag_cmd(1'b0, 1'b1, 32'h0);
      wait_ack();
      chk("ptr_wrap", 32'(bus.jtag_ptr), 32'h00);
      t = cyc;
      push_mem(1'b1, 8'h00, 32'h0000_0077, 4'hF, t + 1);
      push_done(1'b1, 1'b0, 32'h0, t + 2);
      jtag_cmd(1'b1, 1'b1, 32'h0000_0077);
      tick();
      load_ptr(8'h80);
      chk("ptr_load_wins", 32'(bus.jtag_ptr), 32'h80);

      // Reset in RDWAIT abandons the access.
      push_mem(1'b0, 8'h80, 32'h0, 4'hF, -1);
      jtag_cmd(1'b0, 1'b1, 32'h0);
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("midrst_waitrequest", 32'(bus.avl_waitrequest), 32'd1);
      chk("midrst_ack", 32'(bus.jtag_ack), 32'd0);
      chk("midrst_ptr", 32'(bus.jtag_ptr), 32'd0);
      chk("midrst_busy", 32'(bus.jtag_busy), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick(); tick();
      chk("post_rst_ptr", 32'(bus.jtag_ptr), 32'd0);
      t = cyc;
      push_mem(1'b0, 8'h05, 32'h0, 4'hF, t + 1);
      push_done(1'b0, 1'b1, 32'h1234_5678, t + 4);
      avl_xfer(1'b1, 1'b0, 8'h05, 32'h0, 4'hF);
      push_mem(1'b0, 8'h00, 32'h0, 4'hF, -1);
      push_done(1'b1, 1'b1, 32'h0000_0077, -1);
      jtag_cmd(1'b0, 1'b1, 32'h0);
      wait_ack();
      chk("post_rst_ptr_inc", 32'(bus.jtag_ptr), 32'd1);

      for (int i = 0; i < 20 && (mq.size() != 0 || dq.size() != 0); i++) tick();
      chk("mem_queue_drained", 32'(mq.size()), 32'd0);
      chk("done_queue_drained", 32'(dq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
